// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with TRAP on illegal opcode or memory timeout.
// Optional RV_MC_PERF_CNT_EN adds cycle_cnt / instret_cnt performance counters.
module rv_multicycle_ctrl #(
  parameter int OPW     = 7,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           br_taken,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           mem_addr_sel,
  output logic           ir_we,
  output logic           pc_we,
  output logic [1:0]     pc_sel,
  output logic [2:0]     imm_type,
  output logic           alu_src_b,
  output logic           reg_we,
  output logic [1:0]     wb_sel,
  output logic           busy,
  output logic           trap,
  output logic [2:0]     state_o
`ifdef RV_MC_PERF_CNT_EN
  ,
  output logic [31:0]    cycle_cnt,
  output logic [31:0]    instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_ILL
  } cls_t;

  localparam logic [OPW-1:0] OPC_LOAD   = OPW'(7'b0000011);
  localparam logic [OPW-1:0] OPC_OPIMM  = OPW'(7'b0010011);
  localparam logic [OPW-1:0] OPC_STORE  = OPW'(7'b0100011);
  localparam logic [OPW-1:0] OPC_BRANCH = OPW'(7'b1100011);
  localparam logic [OPW-1:0] OPC_JAL    = OPW'(7'b1101111);
  localparam logic [OPW-1:0] OPC_JALR   = OPW'(7'b1100111);
  localparam logic [OPW-1:0] OPC_OP     = OPW'(7'b0110011);

  localparam int CW = $clog2(TIMEOUT + 2);

  state_t          state, state_nxt;
  cls_t            cls, dec_cls;
  logic [CW-1:0]   tmo_cnt, tmo_nxt;
  logic            ir_we_c, pc_we_c, reg_we_c, mem_we_c;
  logic            waiting;

  function automatic logic [2:0] imm_of(input cls_t c);
    case (c)
      C_LOAD, C_OPIMM, C_JALR: imm_of = 3'd0;
      C_STORE:                 imm_of = 3'd1;
      C_BRANCH:                imm_of = 3'd2;
      C_JAL:                   imm_of = 3'd3;
      default:                 imm_of = 3'd7;
    endcase
  endfunction

  always_comb begin
    dec_cls = C_ILL;
    case (opcode)
      OPC_LOAD:   dec_cls = C_LOAD;
      OPC_OPIMM:  dec_cls = C_OPIMM;
      OPC_STORE:  dec_cls = C_STORE;
      OPC_BRANCH: dec_cls = C_BRANCH;
      OPC_JAL:    dec_cls = C_JAL;
      OPC_JALR:   dec_cls = C_JALR;
      OPC_OP:     dec_cls = C_OP;
      default:    dec_cls = C_ILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      cls     <= C_OP;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_nxt;
      if (state == S_DECODE) cls <= dec_cls;
    end
  end

  always_comb begin
    state_nxt    = state;
    mem_req      = 1'b0;
    mem_we_c     = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we_c      = 1'b0;
    pc_we_c      = 1'b0;
    pc_sel       = 2'd0;
    imm_type     = 3'd7;
    alu_src_b    = 1'b0;
    reg_we_c     = 1'b0;
    wb_sel       = 2'd0;
    busy         = 1'b1;
    trap         = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we_c   = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: state_nxt = (dec_cls == C_ILL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        imm_type  = imm_of(cls);
        alu_src_b = !(cls == C_OP || cls == C_BRANCH);
        case (cls)
          C_BRANCH: begin
            pc_we_c   = 1'b1;
            pc_sel    = br_taken ? 2'd1 : 2'd0;
            state_nxt = S_FETCH;
          end
          C_JAL: begin
            pc_we_c   = 1'b1;
            pc_sel    = 2'd1;
            state_nxt = S_WB;
          end
          C_JALR: begin
            pc_we_c   = 1'b1;
            pc_sel    = 2'd2;
            state_nxt = S_WB;
          end
          C_LOAD, C_STORE: state_nxt = S_MEM;
          default:         state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        imm_type     = imm_of(cls);
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we_c     = (cls == C_STORE);
        if (mem_ready) begin
          if (cls == C_STORE) begin
            pc_we_c   = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        imm_type  = imm_of(cls);
        reg_we_c  = 1'b1;
        if (cls == C_LOAD)                       wb_sel = 2'd1;
        else if (cls == C_JAL || cls == C_JALR)  wb_sel = 2'd2;
        pc_we_c   = !(cls == C_JAL || cls == C_JALR);
        state_nxt = S_FETCH;
      end
      S_TRAP: begin
        busy = 1'b0;
        trap = 1'b1;
      end
      default: state_nxt = S_TRAP;
    endcase

    // Stalled memory request: the counter tracks consecutive wait cycles within one state.
    waiting = mem_req && !mem_ready;
    if (TIMEOUT != 0 && waiting && tmo_cnt == CW'(TIMEOUT - 1))
      state_nxt = S_TRAP;
    tmo_nxt = (TIMEOUT != 0 && waiting && state_nxt == state) ? tmo_cnt + 1'b1 : '0;
  end

  // A reset cycle abandons the instruction, so no architectural write may escape it.
  assign ir_we   = ir_we_c  & ~rst;
  assign pc_we   = pc_we_c  & ~rst;
  assign reg_we  = reg_we_c & ~rst;
  assign mem_we  = mem_we_c & ~rst;
  assign state_o = state;

`ifdef RV_MC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (busy)  cycle_cnt   <= cycle_cnt + 32'd1;
      if (pc_we) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule
